// File: rtl/i2c_bus_arbiter_if.sv
// Bus bundle between the requester clients, the arbiter and the byte-level I2C master.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface i2c_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_addr_rw;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   rsp_valid;
  logic               rsp_nack;
  logic               rsp_timeout;
  logic [7:0]         rsp_rdata;
  logic               busy;
  logic               m_start;
  logic [7:0]         m_addr_rw;
  logic [7:0]         m_wdata;
  logic               m_abort;
  logic               m_done;
  logic               m_nack;
  logic [7:0]         m_rdata;

  modport master (
    input  req, req_addr_rw, req_wdata, m_done, m_nack, m_rdata,
    output rsp_valid, rsp_nack, rsp_timeout, rsp_rdata, busy,
           m_start, m_addr_rw, m_wdata, m_abort
  );

  modport slave (
    output req, req_addr_rw, req_wdata, m_done, m_nack, m_rdata,
    input  rsp_valid, rsp_nack, rsp_timeout, rsp_rdata, busy,
           m_start, m_addr_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one byte-level I2C master
// between N_REQ requesters, with NACK retry and WAIT-state timeout abort.
module i2c_bus_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input logic               clk,
  input logic               rst,
  i2c_bus_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TMR_W = 16;
  localparam int unsigned RTY_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, gnt_idx, cand;
  logic             gnt_found;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic             nack_q, nack_d, tout_q, tout_d;
  logic             start_q, start_d, abort_q, abort_d, busy_q, busy_d;
  logic [N_REQ-1:0] valid_q, valid_d, owner;

  assign owner = N_REQ'(1) << idx_q;

  // First requesting index strictly after the previous owner, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!gnt_found && bus.req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    retry_d = retry_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    tout_d  = tout_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    valid_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          idx_d   = gnt_idx;
          addr_d  = bus.req_addr_rw[8*gnt_idx +: 8];
          wdata_d = bus.req_wdata[8*gnt_idx +: 8];
          retry_d = '0;
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final timer cycle takes priority over the abort.
        if (bus.m_done) begin
          if (!bus.m_nack) begin
            rdata_d = addr_q[0] ? bus.m_rdata : 8'h00;
            nack_d  = 1'b0;
            tout_d  = 1'b0;
            valid_d = owner;
            state_d = S_RESP;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            start_d = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            rdata_d = 8'h00;
            nack_d  = 1'b1;
            tout_d  = 1'b0;
            valid_d = owner;
            state_d = S_RESP;
          end
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          rdata_d = 8'h00;
          nack_d  = 1'b0;
          tout_d  = 1'b1;
          abort_d = 1'b1;
          valid_d = owner;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP: begin
        last_d  = idx_q;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      retry_q <= '0;
      timer_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      tout_q  <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      tout_q  <= tout_d;
      start_q <= start_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rsp_valid   = valid_q;
  assign bus.rsp_nack    = nack_q;
  assign bus.rsp_timeout = tout_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.m_start     = start_q;
  assign bus.m_addr_rw   = addr_q;
  assign bus.m_wdata     = wdata_q;
  assign bus.m_abort     = abort_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: a behavioural I2C master model answers launches,
// expected completions are queued when requests are posted and popped on rsp_valid.
module tb_i2c_bus_arbiter;
  localparam int unsigned N_REQ     = 4;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned TIMEOUT   = 15;

  typedef struct {
    logic [N_REQ-1:0] valid;
    logic             nack;
    logic             tout;
    logic [7:0]       rdata;
    int               lat;
    logic             gap;
  } exp_t;

  logic clk;
  logic rst;
  i2c_bus_arbiter_if #(.N_REQ(N_REQ)) bus ();

  i2c_bus_arbiter #(
    .N_REQ(N_REQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         start_cyc = 0;
  int         rsp_cyc  = 0;
  int         n_start  = 0;
  int         n_abort  = 0;
  logic       gap_armed = 1'b0;
  int         mdl_lat  = 5;
  logic       mdl_nack = 1'b0;
  logic [7:0] mdl_xor  = 8'h00;
  logic [7:0] mdl_hang = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void expect_rsp(input int i, input logic nack, input logic tout,
                                     input logic [7:0] rdata, input int lat, input logic gap);
    exp_t e;
    e.valid = N_REQ'(1) << i;
    e.nack  = nack;
    e.tout  = tout;
    e.rdata = rdata;
    e.lat   = lat;
    e.gap   = gap;
    sb.push_back(e);
  endfunction

  task automatic post(input int i, input logic [7:0] a, input logic [7:0] w);
    bus.req_addr_rw[8*i +: 8] = a;
    bus.req_wdata[8*i +: 8]   = w;
    bus.req[i]                = 1'b1;
  endtask

  // One cycle: observe outputs at the falling edge, score completions, release served requesters.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.m_start) begin
      n_start++;
      start_cyc = cyc;
      if (gap_armed) begin
        check("start_gap", 32'(cyc - rsp_cyc), 32'd2);
        gap_armed = 1'b0;
      end
    end
    if (bus.m_abort) n_abort++;
    if (bus.rsp_valid != '0) begin
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid",   32'(bus.rsp_valid),   32'(e.valid));
        check("rsp_nack",    32'(bus.rsp_nack),    32'(e.nack));
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tout));
        check("m_abort",     32'(bus.m_abort),     32'(e.tout));
        check("rsp_rdata",   32'(bus.rsp_rdata),   32'(e.rdata));
        check("rsp_latency", 32'(cyc - start_cyc), 32'(e.lat));
        gap_armed = e.gap;
      end
      bus.req = bus.req & ~bus.rsp_valid;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  // Behavioural byte master: m_done mdl_lat cycles after m_start, never for the hang address.
  initial begin
    int cd;
    cd = 0;
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.m_done  = 1'b0;
      bus.m_nack  = 1'b0;
      bus.m_rdata = 8'h00;
      if (!rst || bus.m_abort) begin
        cd = 0;
      end else if (bus.m_start) begin
        cd = (bus.m_addr_rw == mdl_hang) ? 0 : mdl_lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.m_done  = 1'b1;
          bus.m_nack  = mdl_nack;
          bus.m_rdata = bus.m_wdata ^ mdl_xor;
        end
      end
    end
  end

  initial begin
    int s0;
    int a0;
    rst             = 1'b0;
    bus.req         = '0;
    bus.req_addr_rw = '0;
    bus.req_wdata   = '0;

    #12;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_m_start",   32'(bus.m_start),   32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_m_abort",   32'(bus.m_abort),   32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();

    // Single write from requester 0
    post(0, 8'hAA, 8'h3C);
    expect_rsp(0, 1'b0, 1'b0, 8'h00, mdl_lat + 1, 1'b0);
    tick();
    check("wr_m_start",   32'(bus.m_start),   32'd1);
    check("wr_busy",      32'(bus.busy),      32'd1);
    check("wr_m_addr_rw", 32'(bus.m_addr_rw), 32'hAA);
    check("wr_m_wdata",   32'(bus.m_wdata),   32'h3C);
    bus.req_addr_rw[7:0] = 8'h00;
    bus.req_wdata[7:0]   = 8'hFF;
    tick();
    check("wr_addr_held", 32'(bus.m_addr_rw), 32'hAA);
    check("wr_data_held", 32'(bus.m_wdata),   32'h3C);
    drain(200);

    // Read from requester 2
    mdl_xor = 8'h5A;
    post(2, 8'hAB, 8'h00);
    expect_rsp(2, 1'b0, 1'b0, 8'h5A, mdl_lat + 1, 1'b0);
    drain(200);
    mdl_xor = 8'h00;

    // Round-robin after a fresh reset: 0,1,2,3 then 0,2 then 3,0,1
    #2 rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      post(i, 8'(8'h21 + 2*i), 8'(8'h10 + i));
      expect_rsp(i, 1'b0, 1'b0, 8'(8'h10 + i), mdl_lat + 1, i != 3);
    end
    drain(400);
    post(0, 8'h31, 8'hC0);
    post(2, 8'h35, 8'hC2);
    expect_rsp(0, 1'b0, 1'b0, 8'hC0, mdl_lat + 1, 1'b1);
    expect_rsp(2, 1'b0, 1'b0, 8'hC2, mdl_lat + 1, 1'b0);
    drain(300);
    post(0, 8'h39, 8'hD0);
    post(1, 8'h3B, 8'hD1);
    post(3, 8'h3F, 8'hD3);
    expect_rsp(3, 1'b0, 1'b0, 8'hD3, mdl_lat + 1, 1'b1);
    expect_rsp(0, 1'b0, 1'b0, 8'hD0, mdl_lat + 1, 1'b1);
    expect_rsp(1, 1'b0, 1'b0, 8'hD1, mdl_lat + 1, 1'b0);
    drain(400);

    // Persistent NACK: one launch plus MAX_RETRY relaunches
    mdl_nack = 1'b1;
    s0 = n_start;
    post(1, 8'h33, 8'h77);
    expect_rsp(1, 1'b1, 1'b0, 8'h00, mdl_lat + 1, 1'b0);
    drain(300);
    check("nack_starts", 32'(n_start - s0), 32'(MAX_RETRY + 1));
    mdl_nack = 1'b0;

    // Timeout on requester 2, requester 3 pending behind it
    mdl_hang = 8'h44;
    a0 = n_abort;
    post(2, 8'h44, 8'h00);
    post(3, 8'h47, 8'h99);
    expect_rsp(2, 1'b0, 1'b1, 8'h00, TIMEOUT + 2, 1'b1);
    expect_rsp(3, 1'b0, 1'b0, 8'h99, mdl_lat + 1, 1'b0);
    drain(300);
    check("tout_aborts", 32'(n_abort - a0), 32'd1);

    // Reset in the middle of a hung WAIT
    a0 = n_abort;
    post(3, 8'h44, 8'h12);
    repeat (4) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    bus.req = '0;
    #1;
    check("mid_rst_busy",      32'(bus.busy),      32'd0);
    check("mid_rst_m_addr_rw", 32'(bus.m_addr_rw), 32'd0);
    check("mid_rst_m_wdata",   32'(bus.m_wdata),   32'd0);
    check("mid_rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) tick();
    #2 rst = 1'b1;
    post(1, 8'h53, 8'hE1);
    post(0, 8'h51, 8'hE0);
    expect_rsp(0, 1'b0, 1'b0, 8'hE0, mdl_lat + 1, 1'b1);
    expect_rsp(1, 1'b0, 1'b0, 8'hE1, mdl_lat + 1, 1'b0);
    drain(300);
    check("mid_rst_aborts", 32'(n_abort - a0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
